wb_write_arbiter: RTL and testbench
===================================

WB_WRITE_ARBITER -- requirements
Module: wb_write_arbiter

Interface
REQ-001 Parameter DEPTH, default 2: number of pending long-latency result entries (power of two, 2..8).
REQ-002 Parameter MAX_WAIT, default 8: maximum cycles the oldest pending entry may wait before a forced drain.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 pipe_we  input  1  pipeline WB stage requests a register-file write this cycle.
REQ-006 pipe_waddr  input  5  pipeline destination register.
REQ-007 pipe_wdata  input  32  pipeline write data (output of the WB select muxes).
REQ-008 lu_valid  input  1  long-latency unit (mult/div) offers a result.
REQ-009 lu_ready  output  1  arbiter accepts the result; transfer when lu_valid && lu_ready.
REQ-010 lu_waddr  input  5  long-latency destination register.
REQ-011 lu_wdata  input  32  long-latency result data.
REQ-012 pipe_stall  output  1  holds the pipeline WB stage for one cycle during a forced drain.
REQ-013 rf_we / rf_waddr / rf_wdata  output  1/5/32  registered register-file write port.

Function
REQ-014 Output latency SHALL be exactly one cycle: the write selected in cycle N appears on rf_* in cycle N+1.
REQ-015 Writes with address 0 from either source SHALL be dropped and never drive rf_we.
REQ-016 Pipeline writes SHALL have priority; an accepted LU result SHALL enter a DEPTH-entry FIFO (pointers wrap modulo DEPTH).
REQ-017 lu_ready SHALL be 1 iff the FIFO is not full, or is full and being drained this cycle.
REQ-018 The FIFO head SHALL drain to rf_* in any cycle where the pipeline does not present a valid write (pipe_we=0 or pipe_waddr=0) and pipe_stall=0 is not required.
REQ-019 Empty FIFO with idle pipeline and lu_valid=1: LU result SHALL bypass the FIFO directly to rf_* (one-cycle latency), lu_ready=1.
REQ-020 A pipeline write to register R SHALL invalidate every pending FIFO entry with waddr R (younger instruction wins); invalidated entries are discarded when they reach the head, without a write.
REQ-021 An LU result accepted in the same cycle as a pipeline write to the same register SHALL be enqueued (LU is older only if already pending; a new acceptance is treated as younger).
REQ-022 State machine: IDLE (FIFO empty) -> PEND (entry accepted) -> FORCE (head age counter reaches MAX_WAIT) -> PEND or IDLE after the head drains.
REQ-023 Head age counter SHALL reset to 0 on each head change and saturate at MAX_WAIT.
REQ-024 In FORCE, pipe_stall SHALL be 1 for exactly one cycle, the head SHALL drain that cycle, and the pipeline write SHALL be ignored that cycle.
REQ-025 Simultaneous enqueue and dequeue on a full FIFO SHALL keep occupancy unchanged.

Reset
REQ-026 Asserting rst SHALL, asynchronously, clear the FIFO, pointers, age counter, state to IDLE; rf_we=0, rf_waddr=0, rf_wdata=0, pipe_stall=0, lu_ready=1 after release.
REQ-027 Reset mid-operation SHALL discard all pending entries without issuing writes.

Configuration
REQ-028 Macro WB_ARB_FORWARD_EN, when defined, SHALL add fwd_raddr (input 5), fwd_hit (output 1), fwd_data (output 32): combinational lookup returning the youngest valid pending entry matching fwd_raddr (fwd_hit=0 for address 0).
REQ-029 Without WB_ARB_FORWARD_EN those ports SHALL not exist and no lookup logic is built.

Structure
REQ-030 Shared package SHALL hold the state encoding (IDLE, PEND, FORCE), the register-address width (5) and data width (32) constants.
REQ-031 FIFO storage, pointers and per-entry valid bits SHALL be one sub-module, wb_pend_fifo; arbitration and FSM stay in the top.

Verification
REQ-032 Idle pipe, empty FIFO, lu_valid with waddr 5, data 0xDEADBEEF -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
REQ-033 Pipe writes every cycle, two LU results -> lu_ready drops after DEPTH=2 accepted; after MAX_WAIT=8 cycles pipe_stall=1 for one cycle and head written.
REQ-034 LU result for reg 7 pending, pipe writes reg 7 data 0x11 -> rf sees 0x11, pending entry never written.
REQ-035 Either source writing reg 0 -> rf_we stays 0.
REQ-036 rst low with two pending entries -> outputs zero immediately; after release no stale writes occur.
REQ-037 With WB_ARB_FORWARD_EN, pending reg 9 = 0x42, fwd_raddr=9 -> fwd_hit=1, fwd_data=0x42; fwd_raddr=10 -> fwd_hit=0.

Source files
------------

// File: rtl/wb_write_arbiter_pkg.sv
// Shared types and widths for the WB write arbiter and its pending-result FIFO.
package wb_write_arbiter_pkg;

  localparam int unsigned AddrW = 5;
  localparam int unsigned DataW = 32;

  typedef enum logic [1:0] {
    StIdle,
    StPend,
    StForce
  } arb_state_e;

endpackage

// File: rtl/wb_pend_fifo.sv
// Pending long-latency result FIFO: storage, wrapping pointers and per-entry live bits.
// With WB_ARB_FORWARD_EN defined, adds a youngest-live-match lookup port.
module wb_pend_fifo
  import wb_write_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [AddrW-1:0]       push_addr_i,
  input  logic [DataW-1:0]       push_data_i,
  input  logic                   pop_i,
  input  logic                   inval_i,
  input  logic [AddrW-1:0]       inval_addr_i,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   head_live_o,
  output logic [AddrW-1:0]       head_addr_o,
  output logic [DataW-1:0]       head_data_o
`ifdef WB_ARB_FORWARD_EN
  ,
  input  logic [AddrW-1:0]       fwd_raddr_i,
  output logic                   fwd_hit_o,
  output logic [DataW-1:0]       fwd_data_o
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic [DEPTH-1:0] live_q, live_d;
  logic [AddrW-1:0] addr_q [DEPTH];
  logic [AddrW-1:0] addr_d [DEPTH];
  logic [DataW-1:0] data_q [DEPTH];
  logic [DataW-1:0] data_d [DEPTH];

  assign empty_o     = (count_q == '0);
  assign full_o      = (count_q == (PtrW+1)'(DEPTH));
  assign count_o     = count_q;
  assign head_live_o = !empty_o && live_q[rd_ptr_q];
  assign head_addr_o = addr_q[rd_ptr_q];
  assign head_data_o = data_q[rd_ptr_q];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    live_d   = live_q;
    addr_d   = addr_q;
    data_d   = data_q;
    // Kill older entries first so a same-cycle push to the same register survives.
    if (inval_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (addr_q[i] == inval_addr_i) live_d[i] = 1'b0;
      end
    end
    if (pop_i) rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push_i) begin
      live_d[wr_ptr_q] = 1'b1;
      addr_d[wr_ptr_q] = push_addr_i;
      data_d[wr_ptr_q] = push_data_i;
      wr_ptr_d         = wr_ptr_q + PtrW'(1);
    end
    if (push_i && !pop_i) begin
      count_d = count_q + (PtrW+1)'(1);
    end else if (!push_i && pop_i) begin
      count_d = count_q - (PtrW+1)'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      live_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      live_q   <= live_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

`ifdef WB_ARB_FORWARD_EN
  // Walk oldest to youngest so the last live match wins.
  always_comb begin
    logic [PtrW-1:0] idx;
    idx        = '0;
    fwd_hit_o  = 1'b0;
    fwd_data_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PtrW'(i);
      if (((PtrW+1)'(i) < count_q) && live_q[idx] && (addr_q[idx] == fwd_raddr_i)) begin
        fwd_hit_o  = 1'b1;
        fwd_data_o = data_q[idx];
      end
    end
    if (fwd_raddr_i == '0) begin
      fwd_hit_o  = 1'b0;
      fwd_data_o = '0;
    end
  end
`endif

endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write arbiter: pipeline WB has priority, long-latency results queue and drain.
// Optional forwarding lookup ports are built when WB_ARB_FORWARD_EN is defined.
module wb_write_arbiter
  import wb_write_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pipe_we,
  input  logic [AddrW-1:0] pipe_waddr,
  input  logic [DataW-1:0] pipe_wdata,
  input  logic             lu_valid,
  output logic             lu_ready,
  input  logic [AddrW-1:0] lu_waddr,
  input  logic [DataW-1:0] lu_wdata,
  output logic             pipe_stall,
  output logic             rf_we,
  output logic [AddrW-1:0] rf_waddr,
  output logic [DataW-1:0] rf_wdata
`ifdef WB_ARB_FORWARD_EN
  ,
  input  logic [AddrW-1:0] fwd_raddr,
  output logic             fwd_hit,
  output logic [DataW-1:0] fwd_data
`endif
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam int unsigned AgeW = $clog2(MAX_WAIT + 1);
  localparam logic [AgeW-1:0] AgeMax = AgeW'(MAX_WAIT);

  arb_state_e state_q, state_d;
  logic [AgeW-1:0]  age_q, age_d;
  logic             rf_we_q, rf_we_d;
  logic [AddrW-1:0] rf_waddr_q, rf_waddr_d;
  logic [DataW-1:0] rf_wdata_q, rf_wdata_d;

  logic             fifo_empty, fifo_full, head_live;
  logic [CntW-1:0]  fifo_count;
  logic [AddrW-1:0] head_addr;
  logic [DataW-1:0] head_data;
  logic             pipe_valid, lu_live, force_drain;
  logic             pop, push, bypass, inval, head_change, occ_next_zero;

  assign pipe_valid  = pipe_we && (pipe_waddr != '0);
  assign lu_live     = lu_valid && (lu_waddr != '0);
  assign force_drain = (state_q == StForce);

  // Write selection; a dead head is discarded even while the pipeline owns the port.
  always_comb begin
    pop        = 1'b0;
    bypass     = 1'b0;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (force_drain) begin
      pop = !fifo_empty;
      if (head_live) begin
        rf_we_d    = 1'b1;
        rf_waddr_d = head_addr;
        rf_wdata_d = head_data;
      end
    end else if (pipe_valid) begin
      pop        = !fifo_empty && !head_live;
      rf_we_d    = 1'b1;
      rf_waddr_d = pipe_waddr;
      rf_wdata_d = pipe_wdata;
    end else if (!fifo_empty) begin
      pop = 1'b1;
      if (head_live) begin
        rf_we_d    = 1'b1;
        rf_waddr_d = head_addr;
        rf_wdata_d = head_data;
      end
    end else if (lu_live) begin
      bypass     = 1'b1;
      rf_we_d    = 1'b1;
      rf_waddr_d = lu_waddr;
      rf_wdata_d = lu_wdata;
    end
  end

  assign lu_ready   = !fifo_full || pop;
  assign push       = lu_live && lu_ready && !bypass;
  assign inval      = pipe_valid && !force_drain;
  assign pipe_stall = force_drain;

  assign head_change   = pop || fifo_empty;
  assign occ_next_zero = fifo_empty ? !push
                                    : ((fifo_count == CntW'(1)) && pop && !push);

  always_comb begin
    state_d = state_q;
    age_d   = age_q;
    if (head_change) begin
      age_d = '0;
    end else if (age_q != AgeMax) begin
      age_d = age_q + AgeW'(1);
    end
    unique case (state_q)
      StIdle, StPend: begin
        if (occ_next_zero)                       state_d = StIdle;
        else if (!head_change && age_d == AgeMax) state_d = StForce;
        else                                      state_d = StPend;
      end
      StForce: state_d = occ_next_zero ? StIdle : StPend;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      age_q      <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      age_q      <= age_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

  wb_pend_fifo #(
    .DEPTH(DEPTH)
  ) u_pend_fifo (
    .clk_i       (clk),
    .rst_ni      (rst),
    .push_i      (push),
    .push_addr_i (lu_waddr),
    .push_data_i (lu_wdata),
    .pop_i       (pop),
    .inval_i     (inval),
    .inval_addr_i(pipe_waddr),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .count_o     (fifo_count),
    .head_live_o (head_live),
    .head_addr_o (head_addr),
    .head_data_o (head_data)
`ifdef WB_ARB_FORWARD_EN
    ,
    .fwd_raddr_i (fwd_raddr),
    .fwd_hit_o   (fwd_hit),
    .fwd_data_o  (fwd_data)
`endif
  );

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: cycle vector table plus forced-drain, reset and forwarding.
module tb_wb_write_arbiter;

  logic        clk;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_waddr;
  logic [31:0] lu_wdata;
  logic        pipe_stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  fwd_raddr;
  logic        fwd_hit;
  logic [31:0] fwd_data;

  int checks = 0;
  int errors = 0;

  wb_write_arbiter #(
    .DEPTH   (2),
    .MAX_WAIT(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pipe_we   (pipe_we),
    .pipe_waddr(pipe_waddr),
    .pipe_wdata(pipe_wdata),
    .lu_valid  (lu_valid),
    .lu_ready  (lu_ready),
    .lu_waddr  (lu_waddr),
    .lu_wdata  (lu_wdata),
    .pipe_stall(pipe_stall),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata)
`ifdef WB_ARB_FORWARD_EN
    ,
    .fwd_raddr (fwd_raddr),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pwe;
    logic [4:0]  pa;
    logic [31:0] pd;
    logic        lv;
    logic [4:0]  la;
    logic [31:0] ld;
    logic        e_rdy;
    logic        e_stall;
    logic        e_we;
    logic [4:0]  e_a;
    logic [31:0] e_d;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld);
    pipe_we    = pwe;
    pipe_waddr = pa;
    pipe_wdata = pd;
    lu_valid   = lv;
    lu_waddr   = la;
    lu_wdata   = ld;
  endtask

  // Inputs already applied; check this cycle's comb outputs, then the registered write.
  task automatic cycle_chk(input string tag, input logic e_rdy, input logic e_stall,
                           input logic e_we, input logic [4:0] e_a, input logic [31:0] e_d);
    @(negedge clk);
    chk({tag, " lu_ready"}, {31'd0, lu_ready}, {31'd0, e_rdy});
    chk({tag, " pipe_stall"}, {31'd0, pipe_stall}, {31'd0, e_stall});
    @(posedge clk);
    #1;
    chk({tag, " rf_we"}, {31'd0, rf_we}, {31'd0, e_we});
    if (e_we) begin
      chk({tag, " rf_waddr"}, {27'd0, rf_waddr}, {27'd0, e_a});
      chk({tag, " rf_wdata"}, rf_wdata, e_d);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int stall_k;
    rst       = 1'b1;
    fwd_raddr = 5'd0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    //               pwe  pa     pd            lv   la     ld            rdy  stl  we   a      d
    vecs[0]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0, 5'd0,  32'h0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 5'd5,  32'hDEADBEEF};
    vecs[2]  = '{1'b1, 5'd0,  32'h0000AAAA, 1'b1, 5'd0,  32'h0000BBBB, 1'b1, 1'b0, 1'b0, 5'd0,  32'h0};
    vecs[3]  = '{1'b1, 5'd2,  32'h22,       1'b1, 5'd7,  32'h77,       1'b1, 1'b0, 1'b1, 5'd2,  32'h22};
    vecs[4]  = '{1'b1, 5'd7,  32'h11,       1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b1, 5'd7,  32'h11};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0, 5'd0,  32'h0};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0, 5'd0,  32'h0};
    vecs[7]  = '{1'b1, 5'd8,  32'h80,       1'b1, 5'd8,  32'h88,       1'b1, 1'b0, 1'b1, 5'd8,  32'h80};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b1, 5'd8,  32'h88};
    vecs[9]  = '{1'b1, 5'd9,  32'h90,       1'b1, 5'd10, 32'hA0,       1'b1, 1'b0, 1'b1, 5'd9,  32'h90};
    vecs[10] = '{1'b1, 5'd11, 32'hB0,       1'b1, 5'd12, 32'hC0,       1'b1, 1'b0, 1'b1, 5'd11, 32'hB0};
    vecs[11] = '{1'b1, 5'd13, 32'hD0,       1'b1, 5'd14, 32'hE0,       1'b0, 1'b0, 1'b1, 5'd13, 32'hD0};
    vecs[12] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd14, 32'hE0,       1'b1, 1'b0, 1'b1, 5'd10, 32'hA0};
    vecs[13] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b1, 5'd12, 32'hC0};
    vecs[14] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b1, 5'd14, 32'hE0};
    vecs[15] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0, 5'd0,  32'h0};

    // Power-on reset.
    #3 rst = 1'b0;
    #1;
    chk("reset rf_we", {31'd0, rf_we}, 32'd0);
    chk("reset rf_waddr", {27'd0, rf_waddr}, 32'd0);
    chk("reset rf_wdata", rf_wdata, 32'd0);
    chk("reset pipe_stall", {31'd0, pipe_stall}, 32'd0);
    #18 rst = 1'b1;
    #1;
    chk("reset lu_ready", {31'd0, lu_ready}, 32'd1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].pwe, vecs[i].pa, vecs[i].pd, vecs[i].lv, vecs[i].la, vecs[i].ld);
      cycle_chk($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_stall,
                vecs[i].e_we, vecs[i].e_a, vecs[i].e_d);
    end

    // Forced drain: pipe writes every cycle, two LU results fill the FIFO.
    drive(1'b1, 5'd1, 32'h100, 1'b1, 5'd3, 32'h333);
    cycle_chk("force c0", 1'b1, 1'b0, 1'b1, 5'd1, 32'h100);
    drive(1'b1, 5'd1, 32'h101, 1'b1, 5'd4, 32'h444);
    cycle_chk("force c1", 1'b1, 1'b0, 1'b1, 5'd1, 32'h101);
    drive(1'b1, 5'd1, 32'h102, 1'b1, 5'd6, 32'h666);
    cycle_chk("force c2 full", 1'b0, 1'b0, 1'b1, 5'd1, 32'h102);
    stall_k = -1;
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 5'd1, 32'h200 + k, 1'b0, 5'd0, 32'h0);
      @(negedge clk);
      if (pipe_stall) begin
        stall_k = k;
        chk("force lu_ready", {31'd0, lu_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk("force rf_we", {31'd0, rf_we}, 32'd1);
        chk("force rf_waddr", {27'd0, rf_waddr}, 32'd3);
        chk("force rf_wdata", rf_wdata, 32'h333);
        break;
      end
      @(posedge clk);
      #1;
      chk("force pipe rf_wdata", rf_wdata, 32'h200 + k);
    end
    chk("force stall cycle", stall_k, 32'd6);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    cycle_chk("force after", 1'b1, 1'b0, 1'b1, 5'd4, 32'h444);
    cycle_chk("force empty", 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);

    // Reset with two pending entries.
    drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd20, 32'h2020);
    cycle_chk("rst c0", 1'b1, 1'b0, 1'b1, 5'd1, 32'h1);
    drive(1'b1, 5'd1, 32'h2, 1'b1, 5'd21, 32'h2121);
    cycle_chk("rst c1", 1'b1, 1'b0, 1'b1, 5'd1, 32'h2);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1 rst = 1'b0;
    #1;
    chk("midrst rf_we", {31'd0, rf_we}, 32'd0);
    chk("midrst rf_waddr", {27'd0, rf_waddr}, 32'd0);
    chk("midrst rf_wdata", rf_wdata, 32'd0);
    chk("midrst pipe_stall", {31'd0, pipe_stall}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      cycle_chk($sformatf("postrst%0d", k), 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    end

`ifdef WB_ARB_FORWARD_EN
    drive(1'b1, 5'd1, 32'h3, 1'b1, 5'd9, 32'h42);
    cycle_chk("fwd c0", 1'b1, 1'b0, 1'b1, 5'd1, 32'h3);
    drive(1'b1, 5'd1, 32'h4, 1'b0, 5'd0, 32'h0);
    fwd_raddr = 5'd9;
    #1;
    chk("fwd hit9", {31'd0, fwd_hit}, 32'd1);
    chk("fwd data9", fwd_data, 32'h42);
    fwd_raddr = 5'd10;
    #1;
    chk("fwd miss10", {31'd0, fwd_hit}, 32'd0);
    fwd_raddr = 5'd0;
    #1;
    chk("fwd miss0", {31'd0, fwd_hit}, 32'd0);
    drive(1'b1, 5'd1, 32'h4, 1'b1, 5'd9, 32'h55);
    cycle_chk("fwd c1", 1'b1, 1'b0, 1'b1, 5'd1, 32'h4);
    drive(1'b1, 5'd1, 32'h5, 1'b0, 5'd0, 32'h0);
    fwd_raddr = 5'd9;
    #1;
    chk("fwd youngest hit", {31'd0, fwd_hit}, 32'd1);
    chk("fwd youngest data", fwd_data, 32'h55);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
